fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the simple RISC CPU. It sits directly upstream of the execute/datapath controller. It owns the program counter and loads it from `start_pc` after reset. It reads 16-bit instructions from a synchronous instruction RAM, holds each one in the instruction register until execute accepts it, applies branch redirects, and stops permanently on a HALT opcode.

## Interface
Parameters:
- `ADDR_W`, default 8: PC and memory address width.
- `INSTR_W`, default 16: instruction width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start_pc` input ADDR_W: first fetch address; sampled once, in the first cycle after reset release.
- `mem_addr` output ADDR_W: instruction RAM address; always equals `pc`.
- `mem_rd` output 1: RAM read strobe.
- `mem_rdata` input INSTR_W: RAM read data; valid the cycle after the cycle with `mem_rd`=1.
- `ir` output INSTR_W: current instruction register.
- `ir_valid` output 1: `ir` holds an unconsumed instruction.
- `ir_ready` input 1: execute accepts `ir` this cycle.
- `branch_en` input 1: redirect the PC; honoured only in the handshake cycle.
- `branch_target` input ADDR_W: redirect address.
- `pc` output ADDR_W: program counter, the next address to fetch.
- `halt` output 1: a HALT instruction was fetched; sticky.

## Operation
- States: S_LOAD, S_ISSUE, S_CAPTURE, S_HOLD, S_HALT.
- Reset (async, `rst_n`=0):
  - state=S_LOAD.
  - `pc`=0, `ir`=0.
  - `ir_valid`=0, `mem_rd`=0, `halt`=0.
- S_LOAD: `pc`<=`start_pc`; go to S_ISSUE.
- S_ISSUE: `mem_rd`=1, `mem_addr`=`pc`; go to S_CAPTURE.
- S_CAPTURE: `ir`<=`mem_rdata` and `pc`<=`pc`+1 (wraps 8'hFF to 8'h00).
  - If `mem_rdata[15:13]`==3'b111 (HALT), go to S_HALT.
  - Otherwise go to S_HOLD.
- S_HOLD: `ir_valid`=1; `ir` is stable.
  - While `ir_ready`=0, stay in S_HOLD.
  - On `ir_ready`=1: if `branch_en`=1, `pc`<=`branch_target`; go to S_ISSUE.
- S_HALT: `halt`=1, `ir_valid`=0, `mem_rd`=0.
  - `ir` keeps the HALT word; `pc` is frozen.
  - Only reset leaves S_HALT.
- `branch_en` outside a handshake cycle is ignored.
- `ir_ready` outside S_HOLD is ignored.
- A HALT word is never presented with `ir_valid`=1.
- `mem_rd` is 1 only in S_ISSUE.
- `ir_valid` is 1 only in S_HOLD.
- `ir_valid`, `halt` and `mem_rd` are decoded from the state register only; there are no combinational paths from any input to any output.
- Reset asserted mid-operation: everything returns to reset values immediately. An in-flight RAM read is discarded. `start_pc` is resampled after release.

## Timing
- Edge numbering: edge 0 is the first rising edge with `rst_n`=1.
- Edge 0: `pc`=`start_pc`.
- Cycle after edge 0: `mem_rd`=1.
- Edge 2: `ir` and `pc`+1 captured.
- `ir_valid` is 1 from after edge 2 until after the first edge with `ir_ready`=1.
- Steady-state throughput: one instruction per 3 cycles with `ir_ready` held at 1 (ISSUE, CAPTURE, HOLD).
- Branch: the fetch after a handshake with `branch_en`=1 puts `branch_target` on `mem_addr` in the next cycle.
- HALT: `halt` rises the cycle after the CAPTURE edge that loaded the HALT word; it stays high until reset.

## Structure
- `cpu_pkg` holds:
  - opcode constants, including `OP_HALT`=3'b111;
  - the `fetch_state_t` enum;
  - ADDR_W and INSTR_W defaults shared with the datapath and controller.
- No sub-module.
- The PC register, IR register and FSM live in `fetch_unit`.
- The instruction RAM is external. The bench models it as a 256x16 synchronous-read array.

## Test plan
- Reset and start:
  - Stimulus: `start_pc`=8'h10, release reset.
  - Required: `mem_addr`=8'h10 with `mem_rd`=1 in the cycle after edge 0; `ir`=mem[8'h10] with `ir_valid`=1 after edge 2; `pc`=8'h11.
- Backpressure:
  - Stimulus: hold `ir_ready`=0 for 5 cycles, then raise it.
  - Required: `ir` stable and `ir_valid`=1 throughout; the next fetch is from `pc`=8'h11 one cycle after the handshake.
- Branch:
  - Stimulus: at the handshake, `branch_en`=1 and `branch_target`=8'h40.
  - Required: next `mem_addr`=8'h40; `ir`=mem[8'h40].
  - Also: `branch_en`=1 while `ir_ready`=0 has no effect on `pc`.
- HALT:
  - Stimulus: mem[8'h12]=16'hE000.
  - Required: `halt`=1 after edge 8; `ir_valid` stays 0; `mem_rd` stays 0; `pc`=8'h13 frozen for 20 cycles.
- Wrap:
  - Stimulus: `start_pc`=8'hFF.
  - Required: `pc`=8'h00 after the first capture; the second fetch address is 8'h00.
- Mid-operation reset:
  - Stimulus: assert `rst_n`=0 during S_CAPTURE, then release with `start_pc`=8'h20.
  - Required: outputs at reset values immediately, without waiting for a clock edge; the first fetch after release is from 8'h20.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM states
// and default bus widths for fetch, datapath and control.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = 3;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPC_W-1:0] OP_LD   = 3'b100;
  localparam logic [OPC_W-1:0] OP_ST   = 3'b101;
  localparam logic [OPC_W-1:0] OP_BR   = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_LOAD,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD,
    S_HALT
  } fetch_state_t;

  function automatic logic is_halt_op(
    input logic [OPC_W-1:0] opc
  );
    return opc == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, issues RAM
// reads, waits for execute, applies branches, stops on HALT.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halt
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               rdata_halt;
  logic               take;

  assign rdata_halt =
    is_halt_op(mem_rdata[INSTR_W-1 -: OPC_W]);

  assign take = (state_q == S_HOLD) && ir_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:    state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = rdata_halt ? S_HALT : S_HOLD;
      S_HOLD:    if (ir_ready) state_d = S_ISSUE;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_LOAD;
    endcase
  end

  // PC and IR updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      unique case (1'b1)
        state_q == S_LOAD: pc_q <= start_pc;
        state_q == S_CAPTURE: begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + ADDR_W'(1);
        end
        take && branch_en: pc_q <= branch_target;
        default: ;
      endcase
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign mem_rd   = state_q == S_ISSUE;
  assign ir_valid = state_q == S_HOLD;
  assign halt     = state_q == S_HALT;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing cases plus a
// randomized run scored against a fetch-address model.
module tb_fetch_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  start_pc = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 0;
  logic        branch_en = 0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  pc;
  logic        halt;

  logic [15:0] mem [256];

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_pushed;
  logic [7:0] cur_addr = '0;
  logic       mon_en = 0;
  int         idle = 0;
  int         n_hold = 0;

  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_pc(start_pc),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .ir(ir),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .branch_en(branch_en),
    .branch_target(branch_target),
    .pc(pc),
    .halt(halt)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction RAM
  always @(posedge clk)
    if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_valid"}, ir_valid, 0);
    check({tag, "_rd"}, mem_rd, 0);
    check({tag, "_halt"}, halt, 0);
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst_n = 0;
    start_pc = s;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1;
  endtask

  // Scoreboard monitor: pops expected fetch addresses
  always @(negedge clk) begin
    logic [7:0] a;
    if (mon_en && rst_n) begin
      if (mem_rd) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL fetch_extra: got %0h expected none",
                   mem_addr);
        end else begin
          a = exp_q.pop_front();
          check("fetch_addr", mem_addr, a);
          cur_addr = a;
        end
      end else if (ir_valid) begin
        idle = 0;
        n_hold++;
        a = cur_addr + 8'd1;
        check("hold_ir", ir, mem[cur_addr]);
        check("hold_pc", pc, a);
      end else begin
        idle++;
        if (idle > 3) begin
          tests++;
          fails++;
          $display("FAIL watchdog: got %0d idle cycles expected <=3",
                   idle);
          idle = 0;
        end
      end
      check("rand_no_halt", halt, 0);
    end
  end

  initial begin
    logic [7:0] s;
    logic [7:0] nxt;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:13] == 3'b111) mem[i][15] = 1'b0;
    end
    mem[8'h10][0] = 1'b1;

    // Reset, start and HALT with ir_ready held high
    mem[8'h12] = 16'hE000;
    ir_ready = 1;
    do_reset(8'h10);
    tick();
    check("e0_pc", pc, 8'h10);
    check("e0_rd", mem_rd, 1);
    check("e0_addr", mem_addr, 8'h10);
    tick();
    tick();
    check("e2_ir", ir, mem[8'h10]);
    check("e2_valid", ir_valid, 1);
    check("e2_pc", pc, 8'h11);
    for (int e = 3; e <= 8; e++) tick();
    check("e8_halt", halt, 1);
    check("e8_ir", ir, 16'hE000);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("halt_stay", halt, 1);
      check("halt_valid", ir_valid, 0);
      check("halt_rd", mem_rd, 0);
      check("halt_pc", pc, 8'h13);
    end

    // Backpressure, ignored branch, then taken branch
    mem[8'h12] = 16'h1234;
    ir_ready = 0;
    do_reset(8'h10);
    tick();
    tick();
    tick();
    branch_en = 1;
    branch_target = 8'h77;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", ir_valid, 1);
      check("bp_ir", ir, mem[8'h10]);
      check("bp_pc", pc, 8'h11);
    end
    branch_en = 0;
    ir_ready = 1;
    tick();
    check("bp_rd", mem_rd, 1);
    check("bp_addr", mem_addr, 8'h11);
    tick();
    tick();
    check("bp_ir2", ir, mem[8'h11]);
    check("bp_valid2", ir_valid, 1);
    branch_en = 1;
    branch_target = 8'h40;
    tick();
    branch_en = 0;
    check("br_rd", mem_rd, 1);
    check("br_addr", mem_addr, 8'h40);
    tick();
    tick();
    check("br_ir", ir, mem[8'h40]);
    check("br_valid", ir_valid, 1);
    check("br_pc", pc, 8'h41);

    // PC wrap
    do_reset(8'hFF);
    tick();
    tick();
    tick();
    check("wrap_pc", pc, 8'h00);
    check("wrap_ir", ir, mem[8'hFF]);
    tick();
    check("wrap_rd", mem_rd, 1);
    check("wrap_addr", mem_addr, 8'h00);

    // Reset asserted while in CAPTURE
    do_reset(8'h10);
    for (int e = 0; e <= 4; e++) tick();
    check("mid_ir_pre", ir, mem[8'h10]);
    rst_n = 0;
    #1;
    check_reset_vals("mid");
    start_pc = 8'h20;
    @(negedge clk);
    rst_n = 1;
    tick();
    check("mid_rd", mem_rd, 1);
    check("mid_addr", mem_addr, 8'h20);

    // Randomized run against the fetch-address model
    ir_ready = 0;
    s = 8'($urandom);
    exp_q.delete();
    exp_q.push_back(s);
    last_pushed = s;
    do_reset(s);
    idle = 0;
    mon_en = 1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      ir_ready = $urandom_range(0, 2) != 0;
      branch_en = $urandom_range(0, 3) == 0;
      branch_target = 8'($urandom);
      if (ir_valid && ir_ready) begin
        nxt = branch_en ? branch_target
                        : last_pushed + 8'd1;
        exp_q.push_back(nxt);
        last_pushed = nxt;
      end
    end
    mon_en = 0;
    ir_ready = 0;
    branch_en = 0;
    check("rand_holds_seen", n_hold > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
